// File: rtl/norm_prep_stage.sv
// ----------------------------------------------------------------------------
// norm_prep_stage
//
// Normalisation prep stage placed after the adder. It turns a two's-complement
// sum into sign plus magnitude and folds the LZA shift amount, the LZA revise
// bit and the adder carry-out into the exponent. The stage works either on the
// full DW-bit word or on LANES independent packed lanes.
//
// Modes (in_mode):
//   0 full  : magnitude of the whole word. Exponent adjustment depends on
//             cry[0]/shv[0].
//   1 split : per-lane magnitude and per-lane exponent field. Nothing crosses
//             a lane boundary (no borrow, no carry).
//   2 full  : magnitude of the whole word. Unconditional exp+KN-shamt-rev[0].
//   3..7    : illegal. Magnitude and exponent read 0 and out_illegal is 1.
//             The transfer still completes normally.
//
// Exponent arithmetic wraps modulo 2^(field width). out_shamt, out_shv,
// out_rev and out_tag are registered copies of the inputs.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high. The upstream side (in_valid/in_ready) and the downstream side
// (out_valid/out_ready) follow the same rule. Once out_valid is high, the
// output payload holds its value until the cycle in which out_ready is high.
//
// Configuration macro NORM_PREP_SKID_EN:
//   undefined : single output register. in_ready = out_ready | !out_valid
//               (combinational). Accept and emit can happen in the same cycle.
//   defined   : 2-entry skid buffer. in_ready is registered and is high while
//               the buffer is not full. Outputs come from the buffer head.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake
//   in_mode [2:0]           operating mode
//   in_data [DW-1:0]        sum (full) or packed LW-bit lane sums (split)
//   in_exp [EW-1:0]         packed exponent(s)
//   in_shamt [SHW-1:0]      packed LZA shift amount(s)
//   in_shv/in_rev/in_cry    per-lane shift-valid, LZA revise, carry-out
//   in_tag [TW-1:0]         sideband, passed through unchanged
//   out_valid / out_ready   downstream handshake
//   out_mag, out_sign, out_exp, out_shamt, out_shv, out_rev, out_tag,
//   out_illegal             registered results
// ----------------------------------------------------------------------------
module norm_prep_stage #(
    parameter int DW    = 74,
    parameter int LANES = 2,
    parameter int EW    = 12,
    parameter int SHW   = 10,
    parameter int TW    = 16,
    parameter int KC    = 3,
    parameter int KN    = 27,
    parameter int KCL   = 3,
    parameter int KNL   = 14
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_mode,
    input  logic [DW-1:0]    in_data,
    input  logic [EW-1:0]    in_exp,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [LANES-1:0] in_shv,
    input  logic [LANES-1:0] in_rev,
    input  logic [LANES-1:0] in_cry,
    input  logic [TW-1:0]    in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_mag,
    output logic [LANES-1:0] out_sign,
    output logic [EW-1:0]    out_exp,
    output logic [SHW-1:0]   out_shamt,
    output logic [LANES-1:0] out_shv,
    output logic [LANES-1:0] out_rev,
    output logic [TW-1:0]    out_tag,
    output logic             out_illegal
);

    // DW, EW and SHW are expected to be multiples of LANES.
    localparam int LW  = DW / LANES;
    localparam int LEW = EW / LANES;
    localparam int LSW = SHW / LANES;

    localparam logic [2:0] MODE_FULL   = 3'd0;
    localparam logic [2:0] MODE_SPLIT  = 3'd1;
    localparam logic [2:0] MODE_UNCOND = 3'd2;

    typedef struct packed {
        logic             illegal;
        logic [TW-1:0]    tag;
        logic [LANES-1:0] rev;
        logic [LANES-1:0] shv;
        logic [SHW-1:0]   shamt;
        logic [EW-1:0]    exp;
        logic [LANES-1:0] sign;
        logic [DW-1:0]    mag;
    } res_t;

    // ------------------------------------------------------------------
    // Full-word datapath
    // ------------------------------------------------------------------
    logic          full_sign;
    logic [DW-1:0] full_mag;
    logic [EW-1:0] shamt_ext;
    logic [EW-1:0] sh_term;
    logic [EW-1:0] rev_ext;
    logic [EW-1:0] exp_cry;
    logic [EW-1:0] exp_ncry;
    logic [EW-1:0] exp_uncond;
    logic [EW-1:0] exp_full;

    always_comb begin
        full_sign = in_data[DW-1];
        // Negating the most negative value wraps back to itself. As an
        // unsigned magnitude that pattern is the correct 2^(DW-1).
        full_mag  = full_sign ? (~in_data + DW'(1)) : in_data;

        shamt_ext = EW'(in_shamt);
        sh_term   = in_shv[0] ? shamt_ext : '0;
        rev_ext   = EW'(in_rev[0]);

        exp_cry    = in_exp + EW'(KC) - sh_term - rev_ext;
        exp_ncry   = in_exp - shamt_ext - rev_ext + EW'(KN);
        exp_uncond = in_exp + EW'(KN) - shamt_ext - rev_ext;

        if (in_cry[0]) begin
            exp_full = exp_cry;
        end else if (in_shv[0]) begin
            exp_full = exp_ncry;
        end else begin
            exp_full = in_exp;
        end
    end

    // ------------------------------------------------------------------
    // Split-lane datapath. Each lane uses its own slice only, so no borrow
    // or carry can cross a lane boundary.
    // ------------------------------------------------------------------
    logic [DW-1:0]    lane_mag;
    logic [LANES-1:0] lane_sign;
    logic [EW-1:0]    lane_exp;

    always_comb begin
        lane_mag  = '0;
        lane_sign = '0;
        lane_exp  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sign[i] = in_data[i*LW + LW - 1];
            lane_mag[i*LW +: LW] = lane_sign[i] ? (~in_data[i*LW +: LW] + LW'(1))
                                                : in_data[i*LW +: LW];
            lane_exp[i*LEW +: LEW] = in_exp[i*LEW +: LEW]
                                   + (in_cry[i] ? LEW'(KCL) : LEW'(KNL))
                                   - (in_shv[i] ? LEW'(in_shamt[i*LSW +: LSW]) : LEW'(0))
                                   - LEW'(in_rev[i]);
        end
    end

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    res_t res_d;

    always_comb begin
        res_d         = '0;
        res_d.tag     = in_tag;
        res_d.rev     = in_rev;
        res_d.shv     = in_shv;
        res_d.shamt   = in_shamt;
        res_d.illegal = 1'b0;
        case (in_mode)
            MODE_FULL: begin
                res_d.mag     = full_mag;
                res_d.sign[0] = full_sign;
                res_d.exp     = exp_full;
            end
            MODE_SPLIT: begin
                res_d.mag  = lane_mag;
                res_d.sign = lane_sign;
                res_d.exp  = lane_exp;
            end
            MODE_UNCOND: begin
                res_d.mag     = full_mag;
                res_d.sign[0] = full_sign;
                res_d.exp     = exp_uncond;
            end
            default: begin
                // Illegal mode. Sideband copies still travel so the
                // consumer can tell which request went wrong.
                res_d.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output storage
    // ------------------------------------------------------------------
    res_t out_r;

`ifdef NORM_PREP_SKID_EN
    // Two-entry FIFO. in_ready is registered, so it has to predict the
    // occupancy after this edge: it is high whenever the next count is
    // below 2.
    res_t       buf0_q;
    res_t       buf1_q;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       in_ready_q;
    logic       push;
    logic       pop;

    assign push  = in_valid & in_ready_q;
    assign pop   = (cnt_q != 2'd0) & out_ready;
    assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf0_q     <= '0;
            buf1_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                if (wr_ptr_q) begin
                    buf1_q <= res_d;
                end else begin
                    buf0_q <= res_d;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != 2'd2);
        end
    end

    assign out_r     = rd_ptr_q ? buf1_q : buf0_q;
    assign out_valid = (cnt_q != 2'd0);
    assign in_ready  = in_ready_q;
`else
    // Single stage. The register loads whenever it is empty or being
    // drained this cycle, so a new result can replace the old one in the
    // same cycle at full throughput.
    res_t out_q;
    logic valid_q;
    logic load;

    assign in_ready = out_ready | ~valid_q;
    assign load     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load) begin
                out_q   <= res_d;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_r     = out_q;
    assign out_valid = valid_q;
`endif

    assign out_mag     = out_r.mag;
    assign out_sign    = out_r.sign;
    assign out_exp     = out_r.exp;
    assign out_shamt   = out_r.shamt;
    assign out_shv     = out_r.shv;
    assign out_rev     = out_r.rev;
    assign out_tag     = out_r.tag;
    assign out_illegal = out_r.illegal;

endmodule

// File: tb/tb_norm_prep_stage.sv
// ----------------------------------------------------------------------------
// tb_norm_prep_stage
//
// Bench for norm_prep_stage. Checking is done through a scoreboard:
//   - The driver computes the expected result with a reference model and
//     pushes it onto exp_q when the DUT accepts an input.
//   - The monitor pops an entry and compares it whenever an output transfer
//     happens.
//   - The monitor also checks that the outputs hold while they are stalled.
// Directed cases cover the worked examples, the most negative input, an
// illegal mode, a stall with three inputs offered and a reset in the middle of
// the stream. A randomized phase follows.
// ----------------------------------------------------------------------------
module tb_norm_prep_stage;

    localparam int DW    = 74;
    localparam int LANES = 2;
    localparam int EW    = 12;
    localparam int SHW   = 10;
    localparam int TW    = 16;
    localparam int KC    = 3;
    localparam int KN    = 27;
    localparam int KCL   = 3;
    localparam int KNL   = 14;
    localparam int LW    = DW / LANES;
    localparam int LEW   = EW / LANES;
    localparam int LSW   = SHW / LANES;
    localparam int RW    = DW + EW + SHW + TW + 3 * LANES + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_mode = '0;
    logic [DW-1:0]    in_data = '0;
    logic [EW-1:0]    in_exp = '0;
    logic [SHW-1:0]   in_shamt = '0;
    logic [LANES-1:0] in_shv = '0;
    logic [LANES-1:0] in_rev = '0;
    logic [LANES-1:0] in_cry = '0;
    logic [TW-1:0]    in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_mag;
    logic [LANES-1:0] out_sign;
    logic [EW-1:0]    out_exp;
    logic [SHW-1:0]   out_shamt;
    logic [LANES-1:0] out_shv;
    logic [LANES-1:0] out_rev;
    logic [TW-1:0]    out_tag;
    logic             out_illegal;

    norm_prep_stage dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .in_exp     (in_exp),
        .in_shamt   (in_shamt),
        .in_shv     (in_shv),
        .in_rev     (in_rev),
        .in_cry     (in_cry),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mag    (out_mag),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_shamt  (out_shamt),
        .out_shv    (out_shv),
        .out_rev    (out_rev),
        .out_tag    (out_tag),
        .out_illegal(out_illegal)
    );

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int ready_mode = 1;  // 0 random, 1 always high, 2 always low

    function automatic logic [RW-1:0] out_pack();
        return {out_illegal, out_tag, out_rev, out_shv, out_shamt, out_exp, out_sign, out_mag};
    endfunction

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wrap(input int x, input int w);
        int m;
        m = 1 << w;
        return ((x % m) + m) % m;
    endfunction

    function automatic logic [RW-1:0] model(input int mode, input logic [DW-1:0] d,
                                            input logic [EW-1:0] e, input logic [SHW-1:0] sh,
                                            input logic [LANES-1:0] shv, input logic [LANES-1:0] rev,
                                            input logic [LANES-1:0] cry, input logic [TW-1:0] tag);
        logic [DW:0]      pow_full;
        logic [DW:0]      pow_lane;
        logic [DW:0]      seg;
        logic [DW-1:0]    mag;
        logic [LANES-1:0] sg;
        logic [EW-1:0]    eo;
        logic             ill;
        int x, ei, si, ef, sf;
        mag = '0;
        sg  = '0;
        eo  = '0;
        ill = 1'b0;
        x   = 0;
        ei  = int'(e);
        si  = int'(sh);
        pow_full = '0;
        pow_full[DW] = 1'b1;
        pow_lane = '0;
        pow_lane[LW] = 1'b1;
        if (mode == 0 || mode == 2) begin
            sg[0] = d[DW-1];
            // The absolute value is 2^DW - d for negative d. For the most
            // negative value this gives 2^(DW-1) itself.
            mag = sg[0] ? DW'(pow_full - {1'b0, d}) : d;
            if (mode == 2) x = ei + KN - si - int'(rev[0]);
            else if (cry[0]) x = ei + KC - (shv[0] ? si : 0) - int'(rev[0]);
            else if (shv[0]) x = ei - si - int'(rev[0]) + KN;
            else x = ei;
            eo = EW'(wrap(x, EW));
        end else if (mode == 1) begin
            for (int i = 0; i < LANES; i++) begin
                seg = ({1'b0, d} >> (i * LW)) % pow_lane;
                if (seg >= (pow_lane >> 1)) begin
                    sg[i] = 1'b1;
                    seg = pow_lane - seg;
                end
                mag = mag | (DW'(seg) << (i * LW));
                ef = (ei >> (i * LEW)) % (1 << LEW);
                sf = (si >> (i * LSW)) % (1 << LSW);
                x = ef + (cry[i] ? KCL : KNL) - (shv[i] ? sf : 0) - int'(rev[i]);
                eo = eo | (EW'(wrap(x, LEW)) << (i * LEW));
            end
        end else begin
            ill = 1'b1;
        end
        return {ill, tag, rev, shv, sh, eo, sg, mag};
    endfunction

    // ---------------- driver ----------------
    // Must be called at a negedge. Returns at the negedge that follows the
    // accepting edge. waited is the number of edges that passed without
    // acceptance.
    task automatic drive(input int mode, input logic [DW-1:0] d, input logic [EW-1:0] e,
                         input logic [SHW-1:0] sh, input logic [LANES-1:0] shv,
                         input logic [LANES-1:0] rev, input logic [LANES-1:0] cry,
                         input logic [TW-1:0] tag, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        in_mode = 3'(mode);
        in_data = d;
        in_exp = e;
        in_shamt = sh;
        in_shv = shv;
        in_rev = rev;
        in_cry = cry;
        in_tag = tag;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            #4;
            if (in_ready) begin
                exp_q.push_back(model(mode, d, e, sh, shv, rev, cry, tag));
                acc = 1'b1;
            end else begin
                waited++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic drain();
        ready_mode = 1;
        for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(negedge clk);
        check("drain_empty", RW'(exp_q.size()), RW'(0));
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
            0: d = '0;
            1: begin d = '0; d[DW-1] = 1'b1; end
            2: begin d = '0; d[DW-1] = 1'b1; d[LW-1] = 1'b1; end
            3: d = '1;
            default: ;
        endcase
        return d;
    endfunction

    // ---------------- downstream ready ----------------
    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready = ($urandom_range(0, 3) != 0);
                1: out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [RW-1:0] act;
        logic [RW-1:0] held;
        logic [RW-1:0] e;
        bit hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #4;
            act = out_pack();
            if (!rstn) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", RW'(out_valid), RW'(1));
                    check("hold_data", act, held);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output actual=%0h required=none", act);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", act, e);
                    end
                end
                hold = out_valid && !out_ready;
                held = act;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0]    d;
        logic [DW-1:0]    sd[3];
        logic [EW-1:0]    se[3];
        logic [TW-1:0]    st[3];
        int w;
        int acc_n;
        int exp_acc;

        // Outputs during reset
        repeat (3) @(negedge clk);
        #4;
        check("reset_out_valid", RW'(out_valid), RW'(0));
        check("reset_outputs", out_pack(), RW'(0));
        check("reset_in_ready", RW'(in_ready), RW'(1));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Mode 0, -5, exp 100, cry=1, rev=1 -> mag 5, sign 1, exp 102
        d = '1;
        d = d - DW'(4);
        drive(0, d, 12'd100, 10'd0, 2'b00, 2'b01, 2'b01, 16'h1234, w);
        #4;
        check("m0_valid", RW'(out_valid), RW'(1));
        check("m0_mag", RW'(out_mag), RW'(5));
        check("m0_sign", RW'(out_sign), RW'(1));
        check("m0_exp", RW'(out_exp), RW'(102));
        @(negedge clk);

        // Split: lane1=+7, lane0=-1, exp {20,10}, shv {1,0}, shamt lane1=4
        d = (DW'(7) << LW) | ((DW'(1) << LW) - DW'(1));
        drive(1, d, EW'((20 << LEW) | 10), SHW'(4 << LSW), 2'b10, 2'b00, 2'b00, 16'h0042, w);
        #4;
        check("m1_mag", RW'(out_mag), RW'((DW'(7) << LW) | DW'(1)));
        check("m1_sign", RW'(out_sign), RW'(2'b01));
        check("m1_exp", RW'(out_exp), RW'((30 << LEW) | 24));
        @(negedge clk);

        // Mode 2: exp 5, shamt 40, rev 1 -> 4087
        drive(2, DW'(123), 12'd5, 10'd40, 2'b00, 2'b01, 2'b11, 16'h0002, w);
        #4;
        check("m2_exp", RW'(out_exp), RW'(4087));
        @(negedge clk);

        // Most negative value keeps its bit pattern as the magnitude
        d = '0;
        d[DW-1] = 1'b1;
        drive(0, d, 12'd7, 10'd0, 2'b00, 2'b00, 2'b00, 16'h0003, w);
        #4;
        check("minval_mag", RW'(out_mag), RW'(d));
        check("minval_sign", RW'(out_sign), RW'(1));
        @(negedge clk);

        // Illegal mode 6
        drive(6, DW'(55), 12'd300, 10'd3, 2'b11, 2'b11, 2'b11, 16'h0006, w);
        #4;
        check("ill_flag", RW'(out_illegal), RW'(1));
        check("ill_exp", RW'(out_exp), RW'(0));
        check("ill_mag", RW'(out_mag), RW'(0));
        @(negedge clk);
        drain();

        // Stall: out_ready low for 5 cycles while 3 inputs are offered
        ready_mode = 2;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sd[i] = rand_data();
            se[i] = EW'($urandom);
            st[i] = TW'(16'h0100 + i);
        end
        acc_n = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (acc_n < 3);
            if (acc_n < 3) begin
                in_mode = 3'd0;
                in_data = sd[acc_n];
                in_exp = se[acc_n];
                in_shamt = 10'd9;
                in_shv = 2'b01;
                in_rev = 2'b00;
                in_cry = 2'b00;
                in_tag = st[acc_n];
            end
            #4;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(0, sd[acc_n], se[acc_n], 10'd9, 2'b01, 2'b00, 2'b00, st[acc_n]));
                acc_n++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
`ifdef NORM_PREP_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        check("stall_accepts", RW'(acc_n), RW'(exp_acc));
        ready_mode = 1;
        for (int i = acc_n; i < 3; i++) begin
            drive(0, sd[i], se[i], 10'd9, 2'b01, 2'b00, 2'b00, st[i], w);
        end
        drain();

        // Reset in the middle of the stream
        ready_mode = 2;
        @(negedge clk);
        @(negedge clk);
        drive(1, rand_data(), EW'($urandom), SHW'($urandom), 2'b11, 2'b01, 2'b10, 16'h0777, w);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", RW'(out_valid), RW'(0));
        check("midrst_outputs", out_pack(), RW'(0));
        check("midrst_in_ready", RW'(in_ready), RW'(1));
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        ready_mode = 1;
        drive(0, rand_data(), EW'($urandom), SHW'($urandom), 2'b01, 2'b00, 2'b01, 16'h0888, w);
        check("post_reset_first_accept", RW'(w), RW'(0));
        drain();

        // Randomized traffic with random backpressure
        ready_mode = 0;
        for (int n = 0; n < 300; n++) begin
            int m;
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) m = 0;
            else if (r < 6) m = 1;
            else if (r < 8) m = 2;
            else m = $urandom_range(3, 7);
            drive(m, rand_data(), EW'($urandom), SHW'($urandom), LANES'($urandom),
                  LANES'($urandom), LANES'($urandom), TW'($urandom), w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
